// File: rtl/mmc3_pkg.sv
// Shared constants and types for the MMC3 scanline IRQ generator.
// The A12 filter and the counter/IRQ top both import this package.
package mmc3_pkg;

  localparam int unsigned FILT_M2 = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FILT_W  = 2;

  // Register write strobes from the mapper decoder ($C000/$C001/$E000/$E001)
  typedef struct packed {
    logic latch;
    logic reload;
    logic dis;
    logic en;
  } mmc3_wr_t;

  function automatic logic cnt_is_zero(input logic [CNT_W-1:0] cnt);
    return (cnt == '0);
  endfunction

endpackage

// File: rtl/mmc3_a12_filt.sv
// PPU A12 rising-edge filter: emits a one-clk scanline pulse only after A12
// has been low across FILT_M2 CPU M2 falling edges.
module mmc3_a12_filt
  import mmc3_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic m2,
  input  logic ppu_a12,
  output logic a12_pulse
);

  logic              r_m2;
  logic              r_a12;
  logic [FILT_W-1:0] r_low_cnt;
  logic              w_m2_fall;
  logic              w_low_ok;
  logic              w_low_sat;

  assign w_m2_fall = r_m2 & ~m2;
  assign w_low_ok  = (r_low_cnt >= FILT_W'(FILT_M2));
  assign w_low_sat = (r_low_cnt == FILT_W'(FILT_M2));

  // Combinational so the pulse lines up with the A12 rise itself
  assign a12_pulse = ~r_a12 & ppu_a12 & w_low_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m2      <= 1'b0;
      r_a12     <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_m2  <= m2;
      r_a12 <= ppu_a12;
      if (ppu_a12) begin
        r_low_cnt <= '0;
      end else if (w_m2_fall && !w_low_sat) begin
        r_low_cnt <= r_low_cnt + FILT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmc3_irq_gen.sv
// MMC3 scanline counter and IRQ: reload/decrement on each filtered A12 pulse,
// with Sharp (cfg_alt=0) or NEC rev-A (cfg_alt=1) zero-IRQ qualification.
module mmc3_irq_gen
  import mmc3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m2,
  input  logic             ppu_a12,
  input  logic             we_latch,
  input  logic             we_reload,
  input  logic             we_disable,
  input  logic             we_enable,
  input  logic [7:0]       wdat,
  input  logic             cfg_alt,
  output logic             irq,
  output logic             a12_pulse,
  output logic [CNT_W-1:0] irq_count,
  output logic [CNT_W-1:0] irq_latch
);

  mmc3_wr_t         w_wr;
  logic             w_pulse;
  logic             w_old_zero;
  logic             w_reload_eff;
  logic             w_load;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_new_zero;
  logic             w_irq_qual;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_latch;
  logic             r_reload;
  logic             r_en;
  logic             r_irq;

  assign w_wr = '{latch: we_latch, reload: we_reload, dis: we_disable, en: we_enable};

  mmc3_a12_filt u_filt (
    .clk       (clk),
    .rst_n     (rst_n),
    .m2        (m2),
    .ppu_a12   (ppu_a12),
    .a12_pulse (w_pulse)
  );

  // A reload write landing with a pulse counts as a pending reload
  assign w_old_zero   = cnt_is_zero(r_count);
  assign w_reload_eff = r_reload | w_wr.reload;
  assign w_load       = w_old_zero | w_reload_eff;
  assign w_next_cnt   = w_load ? r_latch : (r_count - CNT_W'(1));
  assign w_new_zero   = cnt_is_zero(w_next_cnt);

  always_comb begin
    w_irq_qual = 1'b0;
    if (cfg_alt) begin
      w_irq_qual = w_new_zero & r_en & (~w_old_zero | w_reload_eff);
    end else begin
      w_irq_qual = w_new_zero & r_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_reload <= 1'b0;
    end else if (w_pulse) begin
      r_count  <= w_next_cnt;
      r_reload <= 1'b0;
    end else if (w_wr.reload) begin
      r_count  <= '0;
      r_reload <= 1'b1;
    end
  end

  // Latch write takes effect after any coincident pulse has used the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch <= '0;
    end else if (w_wr.latch) begin
      r_latch <= CNT_W'(wdat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else if (w_wr.dis) begin
      r_en <= 1'b0;
    end else if (w_wr.en) begin
      r_en <= 1'b1;
    end
  end

  // Disable acknowledges and wins over a coincident IRQ-setting pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (w_wr.dis) begin
      r_irq <= 1'b0;
    end else if (w_pulse && w_irq_qual) begin
      r_irq <= 1'b1;
    end
  end

  assign irq       = r_irq;
  assign a12_pulse = w_pulse;
  assign irq_count = r_count;
  assign irq_latch = r_latch;

endmodule

// File: doc/mmc3_irq_gen.md
MMC3_IRQ_GEN -- requirements
Module: mmc3_irq_gen

Interface
REQ-001 SHALL: clk  in  1  system clock, single clock domain for all state.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: m2  in  1  CPU phi2, already synchronised to clk.
REQ-004 SHALL: ppu_a12  in  1  PPU address bit 12, already synchronised to clk.
REQ-005 SHALL: we_latch / we_reload / we_disable / we_enable  in  1 each  one-clk write strobes for $C000 / $C001 / $E000 / $E001, from the mapper register decoder.
REQ-006 SHALL: wdat  in  8  CPU write data, valid with any strobe.
REQ-007 SHALL: cfg_alt  in  1  0 = Sharp IRQ behaviour, 1 = NEC rev-A behaviour; static during operation.
REQ-008 SHALL: irq  out  1  level IRQ request, active-high.
REQ-009 SHALL: a12_pulse  out  1  one-clk filtered scanline clock.
REQ-010 SHALL: irq_count  out  8  live counter, for save-state readback.
REQ-011 SHALL: irq_latch  out  8  live reload value, for save-state readback.

Function
REQ-012 SHALL: m2 falling edge = registered m2 was 1 and current m2 is 0; one-clk event m2_fall.
REQ-013 SHALL: low_cnt (2-bit, saturating at 3) increments on each m2_fall while ppu_a12=0.
REQ-014 SHALL: low_cnt clears to 0 on any clk where ppu_a12=1.
REQ-015 SHALL: a12_pulse asserts for exactly one clk when the registered ppu_a12 is 0, current ppu_a12 is 1, and low_cnt >= FILT_M2 (3).
REQ-016 SHALL: A12 rise with low_cnt < 3 produces no pulse.
REQ-017 SHALL: on a12_pulse, if irq_count=0 or reload_flag=1, load irq_count from irq_latch and clear reload_flag; otherwise decrement irq_count by 1.
REQ-018 SHALL: irq_count never wraps; the decrement path is never taken from 0.
REQ-019 SHALL (cfg_alt=0): set irq on the clk after a12_pulse if the new count is 0 and irq_en=1.
REQ-020 SHALL (cfg_alt=1): set irq only if the new count is 0, irq_en=1, and (old count != 0 or reload_flag was 1).
REQ-021 SHALL: we_latch writes irq_latch <= wdat.
REQ-022 SHALL: we_reload writes irq_count <= 0 and reload_flag <= 1.
REQ-023 SHALL: we_disable writes irq_en <= 0 and irq <= 0 (acknowledge).
REQ-024 SHALL: we_enable writes irq_en <= 1 and leaves irq unchanged.
REQ-025 SHALL: irq, once set, stays set until we_disable or reset.
REQ-026 SHALL: we_latch in the same clk as a12_pulse: the pulse uses the old latch; the new latch takes effect from the next clk.
REQ-027 SHALL: we_reload in the same clk as a12_pulse: the counter loads irq_latch and reload_flag ends at 0.
REQ-028 SHALL: we_disable in the same clk as an IRQ-setting pulse: irq ends at 0 (disable wins).
REQ-029 SHALL: we_enable in the same clk as a pulse: that pulse evaluates with the old irq_en.
REQ-030 SHALL: latency from ppu_a12 rising to a12_pulse is 0 clk; from a12_pulse to irq is 1 clk.

Reset
REQ-031 SHALL: rst_n=0 asynchronously clears irq, a12_pulse, irq_count, irq_latch, irq_en, reload_flag, low_cnt, and the m2/a12 history registers to 0.
REQ-032 SHALL: if reset is applied mid-filter, the first A12 rise after release produces no pulse until 3 m2_fall events have been seen with A12 low.

Structure
REQ-033 SHALL: constants FILT_M2=3 and CNT_W=8 reside in shared package mmc3_pkg.
REQ-034 SHALL: the A12 edge filter (REQ-012..016) be sub-module mmc3_a12_filt; the counter, enable and IRQ logic stay in the top module.

Verification
REQ-035 SHALL: latch=5, reload, enable; A12 low for 3 m2 falls then high, repeated 6 times -> irq rises 1 clk after the 6th a12_pulse; counts seen are 5,4,3,2,1,0.
REQ-036 SHALL: A12 low for only 2 m2 falls, then high -> no a12_pulse; irq_count unchanged.
REQ-037 SHALL: latch=0, enable, 3 pulses, cfg_alt=0 -> irq set after the first pulse; repeat with cfg_alt=1 and no reload write -> irq stays 0; with cfg_alt=1 after a reload write -> irq set.
REQ-038 SHALL: irq=1, we_disable in the same clk as a zero-count pulse -> irq=0, irq_en=0; a subsequent we_enable does not reassert irq until the next qualifying pulse.
REQ-039 SHALL: latch=3, we_latch(9) coincident with a reload pulse -> irq_count=3, then irq_latch reads 9.
REQ-040 SHALL: rst_n low mid-count (count=2) -> all outputs 0 immediately; the first A12 rise after release produces no pulse.
